// File: rtl/text_plane_pkg.sv
// rtl/text_plane_pkg.sv - shared geometry, control codes and state encoding for the text plane
package text_plane_pkg;
  localparam int ROW_NUMBER     = 15;
  localparam int COL_NUMBER     = 40;
  localparam int ROW_BIT_LEN    = 4;
  localparam int COL_BIT_LEN    = 6;
  localparam int CHAR_ID_LENGTH = 8;

  localparam logic [CHAR_ID_LENGTH-1:0] BLANK_CHAR = 8'h00;
  localparam logic [CHAR_ID_LENGTH-1:0] CHAR_LF    = 8'h0A;
  localparam logic [CHAR_ID_LENGTH-1:0] CHAR_CR    = 8'h0D;
  localparam logic [CHAR_ID_LENGTH-1:0] CHAR_BS    = 8'h08;
  localparam logic [CHAR_ID_LENGTH-1:0] CHAR_FF    = 8'h0C;

  // Last valid indices, sized to the index registers so compares stay width-clean
  localparam logic [ROW_BIT_LEN-1:0] ROW_LAST = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0] COL_LAST = COL_BIT_LEN'(COL_NUMBER - 1);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_SCROLL    = 2'd1;
  localparam state_t ST_CLEAR_ROW = 2'd2;
endpackage

// File: rtl/text_cursor_writer_if.sv
// rtl/text_cursor_writer_if.sv - byte stream in, character plane write port out
interface text_cursor_writer_if;
  import text_plane_pkg::*;

  logic [CHAR_ID_LENGTH-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHAR_ID_LENGTH-1:0] wr_data;
  logic [ROW_BIT_LEN-1:0]    wr_row;
  logic [COL_BIT_LEN-1:0]    wr_col;
  logic                      wr_en;
  logic                      push_up;
  logic                      clear_out;

  modport master (
    input  in_data, in_valid,
    output in_ready, wr_data, wr_row, wr_col, wr_en, push_up, clear_out
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, wr_data, wr_row, wr_col, wr_en, push_up, clear_out
  );
endinterface

// File: rtl/text_cursor_writer.sv
// rtl/text_cursor_writer.sv - cursor tracking and plane write sequencing with scroll/blank
module text_cursor_writer
  import text_plane_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  text_cursor_writer_if.master   bus,
  output logic [ROW_BIT_LEN-1:0] cursor_row,
  output logic [COL_BIT_LEN-1:0] cursor_col
);

  state_t                 state;
  logic [COL_BIT_LEN-1:0] clr_cnt;

  assign bus.in_ready = (state == ST_IDLE) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      cursor_row    <= '0;
      cursor_col    <= '0;
      clr_cnt       <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_data   <= '0;
      bus.wr_row    <= '0;
      bus.wr_col    <= '0;
      bus.push_up   <= 1'b0;
      bus.clear_out <= 1'b0;
    end else begin
      bus.wr_en     <= 1'b0;
      bus.push_up   <= 1'b0;
      bus.clear_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            case (bus.in_data)
              CHAR_LF: begin
                cursor_col <= '0;
                if (cursor_row < ROW_LAST) cursor_row <= cursor_row + 1'b1;
                else                       state      <= ST_SCROLL;
              end
              CHAR_CR: cursor_col <= '0;
              CHAR_BS: begin
                // Backspace blanks the cell it lands on; wraps to the previous row end
                if (cursor_col != '0) begin
                  cursor_col  <= cursor_col - 1'b1;
                  bus.wr_en   <= 1'b1;
                  bus.wr_data <= BLANK_CHAR;
                  bus.wr_row  <= cursor_row;
                  bus.wr_col  <= cursor_col - 1'b1;
                end else if (cursor_row != '0) begin
                  cursor_row  <= cursor_row - 1'b1;
                  cursor_col  <= COL_LAST;
                  bus.wr_en   <= 1'b1;
                  bus.wr_data <= BLANK_CHAR;
                  bus.wr_row  <= cursor_row - 1'b1;
                  bus.wr_col  <= COL_LAST;
                end
              end
              CHAR_FF: begin
                bus.clear_out <= 1'b1;
                cursor_row    <= '0;
                cursor_col    <= '0;
              end
              default: begin
                bus.wr_en   <= 1'b1;
                bus.wr_data <= bus.in_data;
                bus.wr_row  <= cursor_row;
                bus.wr_col  <= cursor_col;
                if (cursor_col < COL_LAST) begin
                  cursor_col <= cursor_col + 1'b1;
                end else begin
                  cursor_col <= '0;
                  if (cursor_row < ROW_LAST) cursor_row <= cursor_row + 1'b1;
                  else                       state      <= ST_SCROLL;
                end
              end
            endcase
          end
        end
        ST_SCROLL: begin
          bus.push_up <= 1'b1;
          clr_cnt     <= '0;
          state       <= ST_CLEAR_ROW;
        end
        ST_CLEAR_ROW: begin
          bus.wr_en   <= 1'b1;
          bus.wr_data <= BLANK_CHAR;
          bus.wr_row  <= ROW_LAST;
          bus.wr_col  <= clr_cnt;
          if (clr_cnt == COL_LAST) begin
            state      <= ST_IDLE;
            cursor_row <= ROW_LAST;
            cursor_col <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
